// File: rtl/rank_calc_pkg.sv
// Shared definitions for the rank calculation engine: scheduling mode encoding,
// rank field offsets for the default geometry, and the rank packing helper.
package rank_calc_pkg;

  typedef enum logic {
    MODE_WRR = 1'b0,
    MODE_DRR = 1'b1
  } rank_mode_e;

  localparam int unsigned RANK_ADDR_LSB  = 32'd0;
  localparam int unsigned RANK_ROUND_LSB = 32'd12;
  localparam int unsigned RANK_OVF_LSB   = 32'd29;
  localparam int unsigned RANK_MARK_BIT  = 32'd30;

  // Builds {1'b1, ovf, round, addr=0} for any field geometry; caller truncates.
  function automatic logic [63:0] pack_rank(
    input logic [63:0] ovf,
    input logic [63:0] round,
    input int unsigned ovf_w,
    input int unsigned round_w,
    input int unsigned addr_w
  );
    logic [63:0] ovf_m;
    logic [63:0] round_m;
    ovf_m   = ovf & ((64'd1 << ovf_w) - 64'd1);
    round_m = round & ((64'd1 << round_w) - 64'd1);
    return (64'd1 << (addr_w + round_w + ovf_w)) |
           (ovf_m << (addr_w + round_w)) |
           (round_m << addr_w);
  endfunction

endpackage

// File: rtl/rank_credit_calc.sv
// Combinational next-state for one class: rebase a stale class onto the PIFO
// head, then spend credit or advance one round (with epoch wrap).
module rank_credit_calc
  import rank_calc_pkg::*;
#(
  parameter int OVF_W    = 1,
  parameter int ROUND_W  = 17,
  parameter int WEIGHT_W = 16,
  parameter int PKT_W    = 16
)(
  input  logic                cls_active,
  input  logic [OVF_W-1:0]    cls_ovf,
  input  logic [ROUND_W-1:0]  cls_round,
  input  logic [WEIGHT_W:0]   cls_credit,
  input  logic [WEIGHT_W-1:0] cls_weight,
  input  logic [OVF_W-1:0]    head_ovf,
  input  logic [ROUND_W-1:0]  head_round,
  input  logic                mode,
  input  logic [PKT_W-1:0]    pkt_len,
  output logic [OVF_W-1:0]    nxt_ovf,
  output logic [ROUND_W-1:0]  nxt_round,
  output logic [WEIGHT_W:0]   nxt_credit
);

  // Wide enough for credit+weight and for any packet length.
  localparam int AW = ((WEIGHT_W + 2) > (PKT_W + 1)) ? (WEIGHT_W + 2) : (PKT_W + 1);

  logic               stale_s;
  logic               fits_s;
  logic [OVF_W-1:0]   ovf_e_s;
  logic [ROUND_W-1:0] round_e_s;
  logic [AW-1:0]      weight_s;
  logic [AW-1:0]      credit_e_s;
  logic [AW-1:0]      cost_s;
  logic [AW-1:0]      refill_s;

  // Rebase, cost selection and credit/round update
  always_comb begin
    if (cls_weight == {WEIGHT_W{1'b0}}) begin
      weight_s = AW'(1'b1);
    end else begin
      weight_s = AW'(cls_weight);
    end

    stale_s = !cls_active || (cls_ovf != head_ovf) || (cls_round < head_round);
    if (stale_s) begin
      ovf_e_s    = head_ovf;
      round_e_s  = head_round;
      credit_e_s = weight_s;
    end else begin
      ovf_e_s    = cls_ovf;
      round_e_s  = cls_round;
      credit_e_s = AW'(cls_credit);
    end

    if (rank_mode_e'(mode) == MODE_DRR) begin
      cost_s = AW'(pkt_len);
      fits_s = (credit_e_s >= cost_s);
    end else begin
      cost_s = AW'(1'b1);
      fits_s = (credit_e_s != {AW{1'b0}});
    end

    refill_s = credit_e_s + weight_s;

    if (fits_s) begin
      nxt_ovf    = ovf_e_s;
      nxt_round  = round_e_s;
      nxt_credit = (WEIGHT_W + 1)'(credit_e_s - cost_s);
    end else begin
      // An oversize packet still moves only one round; leftover debt is dropped.
      if (round_e_s == {ROUND_W{1'b1}}) begin
        nxt_round = {ROUND_W{1'b0}};
        nxt_ovf   = ovf_e_s + OVF_W'(1'b1);
      end else begin
        nxt_round = round_e_s + ROUND_W'(1'b1);
        nxt_ovf   = ovf_e_s;
      end
      if (refill_s > cost_s) begin
        nxt_credit = (WEIGHT_W + 1)'(refill_s - cost_s);
      end else begin
        nxt_credit = {(WEIGHT_W + 1){1'b0}};
      end
    end
  end

endmodule

// File: rtl/rank_calc_engine.sv
// Per-class WRR/DRR rank generator for a PIFO: one request per cycle, rank
// returned one cycle later through a ready/valid response register.
module rank_calc_engine
  import rank_calc_pkg::*;
#(
  parameter int CLASS_WIDTH         = 8,
  parameter int WEIGHT_WIDTH        = 16,
  parameter int PKT_WIDTH           = 16,
  parameter int PIFO_OVERFLOW_WIDTH = 1,
  parameter int PIFO_ROUND_WIDTH    = 17,
  parameter int PIFO_ADDR_WIDTH     = 12,
  parameter int RESULT_WIDTH        = 32,
  parameter int DEFAULT_WEIGHT      = 1
)(
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [CLASS_WIDTH-1:0]         req_class_id,
  input  logic [PKT_WIDTH-1:0]           req_pkt_len,
  input  logic                           cfg_mode,
  input  logic                           cfg_wr_en,
  input  logic [CLASS_WIDTH-1:0]         cfg_wr_class,
  input  logic [WEIGHT_WIDTH-1:0]        cfg_wr_weight,
  input  logic                           last_pifo_valid,
  input  logic [PIFO_OVERFLOW_WIDTH-1:0] last_pifo_overflow,
  input  logic [PIFO_ROUND_WIDTH-1:0]    last_pifo_round,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [RESULT_WIDTH-1:0]        resp_data
);

  localparam int NUM_CLASSES  = 2 ** CLASS_WIDTH;
  localparam int CREDIT_WIDTH = WEIGHT_WIDTH + 1;

  logic                           active_r [NUM_CLASSES];
  logic [PIFO_OVERFLOW_WIDTH-1:0] ovf_r    [NUM_CLASSES];
  logic [PIFO_ROUND_WIDTH-1:0]    round_r  [NUM_CLASSES];
  logic [CREDIT_WIDTH-1:0]        credit_r [NUM_CLASSES];
  logic [WEIGHT_WIDTH-1:0]        weight_r [NUM_CLASSES];

  logic [PIFO_OVERFLOW_WIDTH-1:0] g_ovf_r;
  logic [PIFO_ROUND_WIDTH-1:0]    g_round_r;
  logic                           resp_valid_r;
  logic [RESULT_WIDTH-1:0]        resp_data_r;

  logic                           accept_s;
  logic [PIFO_OVERFLOW_WIDTH-1:0] head_ovf_s;
  logic [PIFO_ROUND_WIDTH-1:0]    head_round_s;
  logic [PIFO_OVERFLOW_WIDTH-1:0] nxt_ovf_s;
  logic [PIFO_ROUND_WIDTH-1:0]    nxt_round_s;
  logic [CREDIT_WIDTH-1:0]        nxt_credit_s;

  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;

  // Handshake and effective head (a live dequeue beats the latched one)
  always_comb begin
    req_ready = rstn && (!resp_valid_r || resp_ready);
    accept_s  = req_valid && req_ready;
    if (last_pifo_valid) begin
      head_ovf_s   = last_pifo_overflow;
      head_round_s = last_pifo_round;
    end else begin
      head_ovf_s   = g_ovf_r;
      head_round_s = g_round_r;
    end
  end

  rank_credit_calc #(
    .OVF_W    (PIFO_OVERFLOW_WIDTH),
    .ROUND_W  (PIFO_ROUND_WIDTH),
    .WEIGHT_W (WEIGHT_WIDTH),
    .PKT_W    (PKT_WIDTH)
  ) u_credit_calc (
    .cls_active (active_r[req_class_id]),
    .cls_ovf    (ovf_r[req_class_id]),
    .cls_round  (round_r[req_class_id]),
    .cls_credit (credit_r[req_class_id]),
    .cls_weight (weight_r[req_class_id]),
    .head_ovf   (head_ovf_s),
    .head_round (head_round_s),
    .mode       (cfg_mode),
    .pkt_len    (req_pkt_len),
    .nxt_ovf    (nxt_ovf_s),
    .nxt_round  (nxt_round_s),
    .nxt_credit (nxt_credit_s)
  );

  // Global PIFO head latch
  always_ff @(posedge clk) begin
    if (!rstn) begin
      g_ovf_r   <= {PIFO_OVERFLOW_WIDTH{1'b0}};
      g_round_r <= {PIFO_ROUND_WIDTH{1'b0}};
    end else if (last_pifo_valid) begin
      g_ovf_r   <= last_pifo_overflow;
      g_round_r <= last_pifo_round;
    end
  end

  // Per-class state: weight writes and accepted-request updates
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        active_r[i] <= 1'b0;
        ovf_r[i]    <= {PIFO_OVERFLOW_WIDTH{1'b0}};
        round_r[i]  <= {PIFO_ROUND_WIDTH{1'b0}};
        credit_r[i] <= {CREDIT_WIDTH{1'b0}};
        weight_r[i] <= WEIGHT_WIDTH'(DEFAULT_WEIGHT);
      end
    end else begin
      if (cfg_wr_en) begin
        weight_r[cfg_wr_class] <= cfg_wr_weight;
      end
      if (accept_s) begin
        active_r[req_class_id] <= 1'b1;
        ovf_r[req_class_id]    <= nxt_ovf_s;
        round_r[req_class_id]  <= nxt_round_s;
        credit_r[req_class_id] <= nxt_credit_s;
      end
    end
  end

  // Response register; holds while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rstn) begin
      resp_valid_r <= 1'b0;
      resp_data_r  <= {RESULT_WIDTH{1'b0}};
    end else if (accept_s) begin
      resp_valid_r <= 1'b1;
      resp_data_r  <= RESULT_WIDTH'(pack_rank(64'(nxt_ovf_s), 64'(nxt_round_s),
                                              PIFO_OVERFLOW_WIDTH, PIFO_ROUND_WIDTH,
                                              PIFO_ADDR_WIDTH));
    end else if (resp_ready) begin
      resp_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rank_calc_engine.sv
// Scoreboard bench for rank_calc_engine: stimulus pushes hand-computed ranks,
// a negedge monitor pops and compares on every response handshake.
module tb_rank_calc_engine;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_class_id;
  logic [15:0] req_pkt_len;
  logic        cfg_mode;
  logic        cfg_wr_en;
  logic [7:0]  cfg_wr_class;
  logic [15:0] cfg_wr_weight;
  logic        last_pifo_valid;
  logic [0:0]  last_pifo_overflow;
  logic [16:0] last_pifo_round;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;

  typedef struct {
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  rank_calc_engine dut (
    .clk                (clk),
    .rstn               (rstn),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_class_id       (req_class_id),
    .req_pkt_len        (req_pkt_len),
    .cfg_mode           (cfg_mode),
    .cfg_wr_en          (cfg_wr_en),
    .cfg_wr_class       (cfg_wr_class),
    .cfg_wr_weight      (cfg_wr_weight),
    .last_pifo_valid    (last_pifo_valid),
    .last_pifo_overflow (last_pifo_overflow),
    .last_pifo_round    (last_pifo_round),
    .resp_valid         (resp_valid),
    .resp_ready         (resp_ready),
    .resp_data          (resp_data)
  );

  function automatic logic [31:0] rank_of(input logic ovf, input logic [16:0] round);
    return {1'b0, 1'b1, ovf, round, 12'h000};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and record its expected rank.
  task automatic send(input logic [7:0] cls, input logic [15:0] len, input logic mode,
                      input logic ovf, input logic [16:0] round, input string name);
    int n;
    n = 0;
    req_valid    = 1'b1;
    req_class_id = cls;
    req_pkt_len  = len;
    cfg_mode     = mode;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s_ready_timeout actual=0 required=1", name);
    end else begin
      exp_q.push_back('{rank_of(ovf, round), name});
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] cls, input logic [15:0] w);
    cfg_wr_en     = 1'b1;
    cfg_wr_class  = cls;
    cfg_wr_weight = w;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic pifo(input logic ovf, input logic [16:0] round);
    last_pifo_valid    = 1'b1;
    last_pifo_overflow = ovf;
    last_pifo_round    = round;
    tick();
    last_pifo_valid = 1'b0;
  endtask

  // Monitor: one comparison per completed response handshake
  always @(negedge clk) begin
    if (rstn && resp_valid && resp_ready) begin : mon_blk
      exp_t e;
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_resp actual=0x%08h required=none", resp_data);
      end else begin
        e = exp_q.pop_front();
        check(e.name, resp_data, e.data);
      end
    end
  end

  initial begin
    int n;
    rstn = 1'b0; req_valid = 1'b0; req_class_id = 8'd0; req_pkt_len = 16'd0;
    cfg_mode = 1'b0; cfg_wr_en = 1'b0; cfg_wr_class = 8'd0; cfg_wr_weight = 16'd0;
    last_pifo_valid = 1'b0; last_pifo_overflow = 1'b0; last_pifo_round = 17'd0;
    resp_ready = 1'b1;
    repeat (3) tick();
    check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset_resp_data", resp_data, 32'd0);
    check("reset_req_ready", {31'd0, req_ready}, 32'd0);
    rstn = 1'b1;
    tick();

    // WRR weight 2 from head 0/0
    cfg(8'd3, 16'd2);
    send(8'd3, 16'd0, 1'b0, 1'b0, 17'd0, "wrr_b2b_0");
    send(8'd3, 16'd0, 1'b0, 1'b0, 17'd0, "wrr_b2b_1");
    send(8'd3, 16'd0, 1'b0, 1'b0, 17'd1, "wrr_b2b_2");
    send(8'd3, 16'd0, 1'b0, 1'b0, 17'd1, "wrr_b2b_3");

    // Latched head at round 5 makes class 3 stale; credit 1 then 0
    pifo(1'b0, 17'd5);
    send(8'd3, 16'd0, 1'b0, 1'b0, 17'd5, "stale_rebase");
    send(8'd3, 16'd0, 1'b0, 1'b0, 17'd5, "stale_credit");
    send(8'd3, 16'd0, 1'b0, 1'b0, 17'd6, "stale_advance");

    // Live head in the acceptance cycle, then round wrap into epoch 1
    last_pifo_valid = 1'b1; last_pifo_overflow = 1'b0; last_pifo_round = 17'd131071;
    send(8'd7, 16'd0, 1'b0, 1'b0, 17'd131071, "wrap_at_max");
    last_pifo_valid = 1'b0;
    send(8'd7, 16'd0, 1'b0, 1'b1, 17'd0, "wrap_epoch");

    // DRR quantum 1500: credits 500, 1000, 400, 0
    pifo(1'b0, 17'd0);
    cfg(8'd10, 16'd1500);
    send(8'd10, 16'd1000, 1'b1, 1'b0, 17'd0, "drr_1000a");
    send(8'd10, 16'd1000, 1'b1, 1'b0, 17'd1, "drr_1000b");
    send(8'd10, 16'd600,  1'b1, 1'b0, 17'd1, "drr_600");
    send(8'd10, 16'd400,  1'b1, 1'b0, 17'd1, "drr_400_exact");
    send(8'd10, 16'd1,    1'b1, 1'b0, 17'd2, "drr_1_advance");

    // Weight write in the request cycle: old weight 1 used, then weight 3
    cfg_wr_en = 1'b1; cfg_wr_class = 8'd12; cfg_wr_weight = 16'd3;
    send(8'd12, 16'd0, 1'b0, 1'b0, 17'd0, "wr_same_cycle");
    cfg_wr_en = 1'b0;
    send(8'd12, 16'd0, 1'b0, 1'b0, 17'd1, "wr_new_w_0");
    send(8'd12, 16'd0, 1'b0, 1'b0, 17'd1, "wr_new_w_1");
    send(8'd12, 16'd0, 1'b0, 1'b0, 17'd1, "wr_new_w_2");
    send(8'd12, 16'd0, 1'b0, 1'b0, 17'd2, "wr_new_w_3");

    // Weight 0 behaves as weight 1
    cfg(8'd20, 16'd0);
    send(8'd20, 16'd0, 1'b0, 1'b0, 17'd0, "w0_a");
    send(8'd20, 16'd0, 1'b0, 1'b0, 17'd1, "w0_b");
    send(8'd20, 16'd0, 1'b0, 1'b0, 17'd2, "w0_c");

    // Backpressure: three stalled cycles, then release
    tick();
    resp_ready = 1'b0;
    send(8'd30, 16'd0, 1'b0, 1'b0, 17'd0, "stall_a");
    req_valid = 1'b1; req_class_id = 8'd30; cfg_mode = 1'b0;
    repeat (3) begin
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
      check("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("stall_resp_data", resp_data, rank_of(1'b0, 17'd0));
      tick();
    end
    resp_ready = 1'b1;
    exp_q.push_back('{rank_of(1'b0, 17'd1), "stall_b"});
    tick();
    req_valid = 1'b0;

    // Reset mid-stream with a pending response
    tick();
    send(8'd40, 16'd0, 1'b0, 1'b0, 17'd0, "rst_pre");
    tick();
    resp_ready = 1'b0;
    req_valid = 1'b1; req_class_id = 8'd40; cfg_mode = 1'b0;
    tick();
    req_valid = 1'b0;
    check("rst_pending_valid", {31'd0, resp_valid}, 32'd1);
    rstn = 1'b0;
    tick();
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    rstn = 1'b1;
    resp_ready = 1'b1;
    repeat (2) begin
      tick();
      check("rst_no_output", {31'd0, resp_valid}, 32'd0);
    end
    send(8'd40, 16'd0, 1'b0, 1'b0, 17'd0, "rst_rebase");
    send(8'd12, 16'd0, 1'b0, 1'b0, 17'd0, "rst_weight_a");
    send(8'd12, 16'd0, 1'b0, 1'b0, 17'd1, "rst_weight_b");

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
